// File: rtl/sha2_stream_padder_if.sv
// Handshake bundle for the SHA-2 stream padder.
// Word input on one side, padded block output on the other.
interface sha2_stream_padder_if #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int NB_W    = $clog2(WORD_W) + 1
) ();
  logic               i_valid;
  logic               o_ready;
  logic [WORD_W-1:0]  i_data;
  logic               i_last;
  logic [NB_W-1:0]    i_last_nbits;
  logic               o_block_valid;
  logic               i_block_ready;
  logic [BLOCK_W-1:0] o_block;
  logic               o_block_last;
  logic               o_busy;

  modport master (
    output i_valid, i_data, i_last, i_last_nbits,
    output i_block_ready,
    input  o_ready, o_block_valid, o_block,
    input  o_block_last, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_last, i_last_nbits,
    input  i_block_ready,
    output o_ready, o_block_valid, o_block,
    output o_block_last, o_busy
  );
endinterface

// File: rtl/sha2_stream_padder.sv
// Streaming SHA-2 padder: packs words, counts bits,
// appends the 1 marker and length, sequences pad blocks.
module sha2_stream_padder #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int LEN_W   = BLOCK_W / 8,
  parameter int NB_W    = $clog2(WORD_W) + 1
) (
  input logic i_clk,
  input logic i_rst,
  sha2_stream_padder_if.slave bus
);
  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int V_W    = $clog2(BLOCK_W) + 2;
  localparam int VX_W   = V_W + 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_PAD2
  } state_t;

  state_t             state;
  logic [WC_W-1:0]    wcnt;
  logic [LEN_W-1:0]   len;
  logic [BLOCK_W-1:0] buffer;
  logic               pad2_pend;
  logic               pad2_msb;

  logic               accept;
  logic [NB_W-1:0]    nbits;
  logic [WORD_W-1:0]  mask;
  logic [V_W-1:0]     woff;
  logic [V_W-1:0]     v;
  logic [LEN_W-1:0]   len_next;
  logic [BLOCK_W-1:0] placed;
  logic [BLOCK_W-1:0] marker;
  logic [BLOCK_W-1:0] blk;
  logic               fits;

  assign accept = bus.i_valid && bus.o_ready;
  assign nbits  = bus.i_last_nbits;
  assign woff   = V_W'(wcnt) * V_W'(WORD_W);
  assign v      = woff + V_W'(nbits);

  // Keep only the MSB-aligned valid bits of a final word
  always_comb begin
    mask = '1;
    if (bus.i_last) begin
      mask = ~({WORD_W{1'b1}} >> nbits);
    end
  end

  // Candidate block content and length after this word
  always_comb begin
    placed = {bus.i_data & mask, {(BLOCK_W-WORD_W){1'b0}}} >> woff;
    marker = '0;
    if (bus.i_last && (v < V_W'(BLOCK_W))) begin
      marker = {1'b1, {(BLOCK_W-1){1'b0}}} >> v;
    end
    blk      = buffer | placed | marker;
    len_next = len + (bus.i_last ? LEN_W'(nbits)
                                 : LEN_W'(WORD_W));
    fits     = ({1'b0, v} + VX_W'(LEN_W + 1))
               <= VX_W'(BLOCK_W);
  end

  // Padder FSM with registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= FILL;
      wcnt              <= '0;
      len               <= '0;
      buffer            <= '0;
      pad2_pend         <= 1'b0;
      pad2_msb          <= 1'b0;
      bus.o_ready       <= 1'b0;
      bus.o_block_valid <= 1'b0;
      bus.o_block       <= '0;
      bus.o_block_last  <= 1'b0;
      bus.o_busy        <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          bus.o_ready <= 1'b1;
          if (accept) begin
            bus.o_busy <= 1'b1;
            len        <= len_next;
            if (bus.i_last) begin
              wcnt              <= '0;
              buffer            <= '0;
              bus.o_ready       <= 1'b0;
              bus.o_block_valid <= 1'b1;
              state             <= EMIT;
              if (fits) begin
                bus.o_block      <= blk | BLOCK_W'(len_next);
                bus.o_block_last <= 1'b1;
                pad2_pend        <= 1'b0;
              end else begin
                bus.o_block      <= blk;
                bus.o_block_last <= 1'b0;
                pad2_pend        <= 1'b1;
                pad2_msb         <= (v == V_W'(BLOCK_W));
              end
            end else if (wcnt == WC_MAX) begin
              wcnt              <= '0;
              buffer            <= '0;
              bus.o_block       <= blk;
              bus.o_block_last  <= 1'b0;
              pad2_pend         <= 1'b0;
              bus.o_ready       <= 1'b0;
              bus.o_block_valid <= 1'b1;
              state             <= EMIT;
            end else begin
              wcnt   <= wcnt + 1'b1;
              buffer <= blk;
            end
          end
        end
        EMIT: begin
          if (bus.i_block_ready) begin
            if (pad2_pend) begin
              bus.o_block      <= {pad2_msb, {(BLOCK_W-1){1'b0}}}
                                  | BLOCK_W'(len);
              bus.o_block_last <= 1'b1;
              pad2_pend        <= 1'b0;
              state            <= EMIT_PAD2;
            end else begin
              bus.o_block_valid <= 1'b0;
              bus.o_ready       <= 1'b1;
              state             <= FILL;
              if (bus.o_block_last) begin
                len              <= '0;
                bus.o_busy       <= 1'b0;
                bus.o_block_last <= 1'b0;
              end
            end
          end
        end
        EMIT_PAD2: begin
          if (bus.i_block_ready) begin
            bus.o_block_valid <= 1'b0;
            bus.o_block_last  <= 1'b0;
            bus.o_ready       <= 1'b1;
            bus.o_busy        <= 1'b0;
            len               <= '0;
            state             <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha2_stream_padder.sv
// Bench for sha2_stream_padder: SHA-256 and SHA-512 instances,
// directed messages checked against a block scoreboard.
module tb_sha2_stream_padder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha2_stream_padder_if #(.WORD_W(32), .BLOCK_W(512))  b256 ();
  sha2_stream_padder_if #(.WORD_W(32), .BLOCK_W(1024)) b512 ();

  sha2_stream_padder #(.WORD_W(32), .BLOCK_W(512)) u256 (
    .i_clk(clk), .i_rst(rst), .bus(b256)
  );
  sha2_stream_padder #(.WORD_W(32), .BLOCK_W(1024)) u512 (
    .i_clk(clk), .i_rst(rst), .bus(b512)
  );

  typedef struct {
    logic [1023:0] blk;
    logic          last;
  } exp_t;

  exp_t q256[$];
  exp_t q512[$];
  bit   msgbits[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [511:0] abc_blk;
  logic [511:0] eb;
  logic [31:0]  w;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push256(input logic [511:0] b, input logic l);
    exp_t e;
    e.blk  = 1024'(b);
    e.last = l;
    q256.push_back(e);
  endtask

  // Reference padding: bits, 1, zeros, 64-bit length
  task automatic push_model256();
    bit s[$];
    logic [63:0]  lbits;
    logic [511:0] b;
    int nblk;
    lbits = 64'(msgbits.size());
    s = msgbits;
    s.push_back(1'b1);
    while ((s.size() % 512) != 448) s.push_back(1'b0);
    for (int i = 63; i >= 0; i--) s.push_back(lbits[i]);
    nblk = s.size() / 512;
    for (int k = 0; k < nblk; k++) begin
      for (int i = 0; i < 512; i++) b[511-i] = s[k*512+i];
      push256(b, k == nblk - 1);
    end
    msgbits.delete();
  endtask

  task automatic send256(input logic [31:0] d, input logic l,
                         input int nb);
    int t = 0;
    b256.i_data       = d;
    b256.i_last       = l;
    b256.i_last_nbits = 6'(nb);
    b256.i_valid      = 1'b1;
    for (int k = 0; k < nb; k++) msgbits.push_back(d[31-k]);
    @(negedge clk);
    while (!b256.o_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("accept256_timeout", 512'(t < 50), 512'(1));
    @(posedge clk);
    #1;
    b256.i_valid = 1'b0;
    b256.i_last  = 1'b0;
  endtask

  task automatic send512(input logic [31:0] d, input logic l,
                         input int nb);
    int t = 0;
    b512.i_data       = d;
    b512.i_last       = l;
    b512.i_last_nbits = 6'(nb);
    b512.i_valid      = 1'b1;
    @(negedge clk);
    while (!b512.o_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("accept512_timeout", 512'(t < 50), 512'(1));
    @(posedge clk);
    #1;
    b512.i_valid = 1'b0;
    b512.i_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q256.size() != 0 || q512.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 512'(t < 200), 512'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b256.i_valid = 0; b256.i_data = 0; b256.i_last = 0;
    b256.i_last_nbits = 0; b256.i_block_ready = 1;
    b512.i_valid = 0; b512.i_data = 0; b512.i_last = 0;
    b512.i_last_nbits = 0; b512.i_block_ready = 1;
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[63:0]    = 64'h18;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && b256.o_block_valid && b256.i_block_ready) begin
            chk("sb256_nonempty", 512'(q256.size() != 0), 512'(1));
            if (q256.size() != 0) begin
              e = q256.pop_front();
              chk("blk256", b256.o_block, e.blk[511:0]);
              chk("last256", 512'(b256.o_block_last), 512'(e.last));
            end
          end
          if (!rst && b512.o_block_valid && b512.i_block_ready) begin
            chk("sb512_nonempty", 512'(q512.size() != 0), 512'(1));
            if (q512.size() != 0) begin
              e = q512.pop_front();
              chk("blk512_hi", b512.o_block[1023:512], e.blk[1023:512]);
              chk("blk512_lo", b512.o_block[511:0], e.blk[511:0]);
              chk("last512", 512'(b512.o_block_last), 512'(e.last));
            end
          end
        end
      end
    join_none

    // reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 512'(b256.o_block_valid), 512'(0));
    chk("rst_ready", 512'(b256.o_ready), 512'(0));
    chk("rst_busy", 512'(b256.o_busy), 512'(0));
    chk("rst_block", b256.o_block, 512'(0));
    chk("rst_last", 512'(b256.o_block_last), 512'(0));
    chk("rst_ready512", 512'(b512.o_ready), 512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 512'(b256.o_ready), 512'(1));

    // "abc"
    push256(abc_blk, 1'b1);
    send256(32'h61626300, 1'b1, 24);
    chk("abc_busy", 512'(b256.o_busy), 512'(1));
    chk("abc_valid", 512'(b256.o_block_valid), 512'(1));
    chk("abc_ready_low", 512'(b256.o_ready), 512'(0));
    msgbits.delete();
    drain();
    chk("abc_busy_clear", 512'(b256.o_busy), 512'(0));
    chk("abc_ready_back", 512'(b256.o_ready), 512'(1));

    // 14 full words then empty last word
    eb = '0;
    for (int i = 0; i < 14; i++) eb[511-32*i -: 32] = 32'hA5000000 + i;
    eb[63] = 1'b1;
    push256(eb, 1'b0);
    push256(512'h1C0, 1'b1);
    for (int i = 0; i < 14; i++) send256(32'hA5000000 + i, 1'b0, 32);
    send256(32'hFFFFFFFF, 1'b1, 0);
    msgbits.delete();
    drain();

    // 16 full words, last one full
    eb = '0;
    for (int i = 0; i < 16; i++) eb[511-32*i -: 32] = 32'h3C000000 ^ i;
    push256(eb, 1'b0);
    eb = '0;
    eb[511] = 1'b1;
    eb[63:0] = 64'h200;
    push256(eb, 1'b1);
    for (int i = 0; i < 15; i++) send256(32'h3C000000 ^ i, 1'b0, 32);
    send256(32'h3C00000F, 1'b1, 32);
    msgbits.delete();
    drain();

    // SHA-512 empty message
    begin
      exp_t e;
      e.blk = '0;
      e.blk[1023] = 1'b1;
      e.last = 1'b1;
      q512.push_back(e);
    end
    send512(32'h12345678, 1'b1, 0);
    drain();
    chk("busy512_clear", 512'(b512.o_busy), 512'(0));

    // backpressure on a held block
    b256.i_block_ready = 1'b0;
    send256(32'h61626300, 1'b1, 24);
    msgbits.delete();
    push256(abc_blk, 1'b1);
    w = $urandom;
    b256.i_data  = w;
    b256.i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_block", b256.o_block, abc_blk);
      chk("bp_ready", 512'(b256.o_ready), 512'(0));
      chk("bp_valid", 512'(b256.o_block_valid), 512'(1));
    end
    @(posedge clk);
    #1;
    b256.i_block_ready = 1'b1;
    @(negedge clk);
    chk("bp_not_yet", 512'(b256.o_ready), 512'(0));
    send256(w, 1'b0, 32);

    // two-block message against the reference model
    for (int i = 0; i < 14; i++) send256($urandom, 1'b0, 32);
    send256($urandom, 1'b1, 20);
    push_model256();
    drain();

    // asynchronous reset mid-message
    for (int i = 0; i < 7; i++) send256($urandom, 1'b0, 32);
    chk("mid_busy", 512'(b256.o_busy), 512'(1));
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 512'(b256.o_busy), 512'(0));
    chk("arst_ready", 512'(b256.o_ready), 512'(0));
    chk("arst_valid", 512'(b256.o_block_valid), 512'(0));
    chk("arst_block", b256.o_block, 512'(0));
    msgbits.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push256(abc_blk, 1'b1);
    send256(32'h61626300, 1'b1, 24);
    msgbits.delete();
    drain();
    chk("sb_empty", 512'(q256.size() + q512.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
